// File: rtl/bubble_host_sequencer.sv
// ============================================================================
// Module   : bubble_host_sequencer
// Purpose  : Bubble-memory host page-read sequencer. It runs the setup, seek,
//            replicate and latency phases, then samples the two bubble outputs
//            into bytes that are passed through a 4-entry FIFO.
// Options  : BUBBLE_HOST_CHECKSUM_EN enables the XOR page checksum.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bubble_host_sequencer #(
  parameter int T_SETUP   = 2400,
  parameter int T_BIT     = 120,
  parameter int T_REP     = 34,
  parameter int LAT_BITS  = 16,
  parameter int PAGE_BITS = 256
) (
  input  logic        MCLK,
  input  logic        MRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_page,
  input  logic        cmd_boot,
  output logic        nBSEN,
  output logic        nREPEN,
  output logic        nBOOTEN,
  input  logic        DOUT0,
  input  logic        DOUT1,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_data,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  checksum
);

  localparam int CMAX = (T_SETUP > T_BIT) ? T_SETUP : T_BIT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PMAX = (LAT_BITS > PAGE_BITS) ? LAT_BITS : PAGE_BITS;
  localparam int PW   = ($clog2(PMAX + 1) < 2) ? 2 : $clog2(PMAX + 1);

  localparam logic [CW-1:0] SETUP_END = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] BIT_END   = CW'(T_BIT - 1);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(T_BIT / 2);
  localparam logic [CW-1:0] REP_LEN   = CW'(T_REP);
  localparam logic [PW-1:0] LAT_END   = PW'((LAT_BITS > 0) ? LAT_BITS - 1 : 0);
  localparam logic [PW-1:0] PAGE_END  = PW'(PAGE_BITS - 1);
  localparam bit            LAT_SKIP  = (LAT_BITS == 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SEEK  = 3'd2,
    S_REPL  = 3'd3,
    S_LAT   = 3'd4,
    S_DATA  = 3'd5,
    S_FLUSH = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [11:0]     pos_q, pos_d;
  logic [PW-1:0]   per_q, per_d;
  logic [11:0]     page_q, page_d;
  logic            boot_q, boot_d;
  logic [7:0]      acc_q, acc_d;

  logic            d0_meta_q, d0_sync_q, d1_meta_q, d1_sync_q;

  logic [7:0]      fifo_q [4];
  logic [1:0]      wr_q, rd_q;
  logic [2:0]      cnt_q;
  logic            ovf_q;

  logic            w_accept, w_bit_end, w_sample, w_last_pos, w_push;
  logic            w_pop, w_store, w_active;
  logic [7:0]      w_byte;

  // Bubble outputs are asynchronous to MCLK.
  always_ff @(posedge MCLK or negedge MRST) begin
    if (!MRST) begin
      d0_meta_q <= 1'b0;
      d0_sync_q <= 1'b0;
      d1_meta_q <= 1'b0;
      d1_sync_q <= 1'b0;
    end else begin
      d0_meta_q <= DOUT0;
      d0_sync_q <= d0_meta_q;
      d1_meta_q <= DOUT1;
      d1_sync_q <= d1_meta_q;
    end
  end

  assign w_accept   = cmd_valid && (state_q == S_IDLE);
  assign w_bit_end  = (cyc_q == BIT_END);
  assign w_sample   = (state_q == S_DATA) && (cyc_q == SAMPLE_AT);
  assign w_last_pos = (per_q == PAGE_END);
  // Four positions per byte; the final position flushes a partial byte.
  assign w_push     = w_sample && ((per_q[1:0] == 2'd3) || w_last_pos);

  always_comb begin
    w_byte                     = acc_q;
    w_byte[{per_q[1:0], 1'b0}] = d0_sync_q;
    w_byte[{per_q[1:0], 1'b1}] = d1_sync_q;
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    pos_d   = pos_q;
    per_d   = per_q;
    page_d  = page_q;
    boot_d  = boot_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_SETUP;
          cyc_d   = '0;
          pos_d   = '0;
          per_d   = '0;
          acc_d   = '0;
          page_d  = cmd_page;
          boot_d  = cmd_boot;
        end
      end
      S_SETUP: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == SETUP_END) begin
          cyc_d   = '0;
          pos_d   = '0;
          state_d = (page_q == 12'd0) ? S_REPL : S_SEEK;
        end
      end
      S_SEEK: begin
        cyc_d = cyc_q + 1'b1;
        if (w_bit_end) begin
          cyc_d = '0;
          pos_d = pos_q + 12'd1;
          if (pos_q + 12'd1 == page_q) begin
            state_d = S_REPL;
          end
        end
      end
      S_REPL: begin
        cyc_d = cyc_q + 1'b1;
        if (w_bit_end) begin
          cyc_d   = '0;
          pos_d   = pos_q + 12'd1;
          per_d   = '0;
          state_d = LAT_SKIP ? S_DATA : S_LAT;
        end
      end
      S_LAT: begin
        cyc_d = cyc_q + 1'b1;
        if (w_bit_end) begin
          cyc_d = '0;
          pos_d = pos_q + 12'd1;
          if (per_q == LAT_END) begin
            per_d   = '0;
            state_d = S_DATA;
          end else begin
            per_d = per_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        cyc_d = cyc_q + 1'b1;
        if (w_sample) begin
          acc_d = w_push ? 8'h00 : w_byte;
        end
        if (w_bit_end) begin
          cyc_d = '0;
          pos_d = pos_q + 12'd1;
          if (w_last_pos) begin
            per_d   = '0;
            state_d = S_FLUSH;
          end else begin
            per_d = per_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge MRST) begin
    if (!MRST) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      pos_q   <= '0;
      per_q   <= '0;
      page_q  <= '0;
      boot_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      pos_q   <= pos_d;
      per_q   <= per_d;
      page_q  <= page_d;
      boot_q  <= boot_d;
      acc_q   <= acc_d;
    end
  end

  // A push into a full FIFO still lands when the same cycle pops.
  assign w_pop   = byte_valid && byte_ready;
  assign w_store = w_push && ((cnt_q != 3'd4) || w_pop);

  always_ff @(posedge MCLK or negedge MRST) begin
    if (!MRST) begin
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 8'h00;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (w_store) begin
        fifo_q[wr_q] <= w_byte;
        wr_q         <= wr_q + 2'd1;
      end
      if (w_pop) begin
        rd_q <= rd_q + 2'd1;
      end
      case ({w_store, w_pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (w_accept) begin
        ovf_q <= 1'b0;
      end else if (w_push && !w_store) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef BUBBLE_HOST_CHECKSUM_EN
  logic [7:0] csum_q;

  // Dropped bytes are folded in as well.
  always_ff @(posedge MCLK or negedge MRST) begin
    if (!MRST) begin
      csum_q <= 8'h00;
    end else if (w_accept) begin
      csum_q <= 8'h00;
    end else if (w_push) begin
      csum_q <= csum_q ^ w_byte;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 8'h00;
`endif

  assign w_active   = (state_q == S_SETUP) || (state_q == S_SEEK) ||
                      (state_q == S_REPL)  || (state_q == S_LAT)  ||
                      (state_q == S_DATA);
  assign cmd_ready  = (state_q == S_IDLE);
  assign nBSEN      = !w_active;
  assign nBOOTEN    = !(w_active && boot_q);
  assign nREPEN     = !((state_q == S_REPL) && (cyc_q < REP_LEN));
  assign done       = (state_q == S_FLUSH) && (cnt_q == 3'd0);
  assign byte_valid = (cnt_q != 3'd0);
  assign byte_data  = fifo_q[rd_q];
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bubble_host_sequencer.sv
// ============================================================================
// Module   : tb_bubble_host_sequencer
// Purpose  : Directed self-checking bench for bubble_host_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bubble_host_sequencer;

  localparam int T_SETUP  = 20;
  localparam int T_BIT    = 8;
  localparam int T_REP    = 3;
  localparam int LAT_BITS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, boot, d0, d1, a_rdy, b_rdy;
  logic [11:0] page;

  logic        a_cmd_ready, a_nbsen, a_nrepen, a_nbooten, a_bv, a_done, a_ovf;
  logic [7:0]  a_bd, a_cs;
  logic        b_cmd_ready, b_nbsen, b_nrepen, b_nbooten, b_bv, b_done, b_ovf;
  logic [7:0]  b_bd, b_cs;

  always #5 clk = ~clk;

  bubble_host_sequencer #(
    .T_SETUP(T_SETUP), .T_BIT(T_BIT), .T_REP(T_REP), .LAT_BITS(LAT_BITS), .PAGE_BITS(24)
  ) u_a (
    .MCLK(clk), .MRST(rst_n), .cmd_valid(a_valid), .cmd_ready(a_cmd_ready),
    .cmd_page(page), .cmd_boot(boot), .nBSEN(a_nbsen), .nREPEN(a_nrepen),
    .nBOOTEN(a_nbooten), .DOUT0(d0), .DOUT1(d1), .byte_valid(a_bv),
    .byte_ready(a_rdy), .byte_data(a_bd), .done(a_done), .overflow(a_ovf),
    .checksum(a_cs)
  );

  bubble_host_sequencer #(
    .T_SETUP(T_SETUP), .T_BIT(T_BIT), .T_REP(T_REP), .LAT_BITS(LAT_BITS), .PAGE_BITS(6)
  ) u_b (
    .MCLK(clk), .MRST(rst_n), .cmd_valid(b_valid), .cmd_ready(b_cmd_ready),
    .cmd_page(page), .cmd_boot(boot), .nBSEN(b_nbsen), .nREPEN(b_nrepen),
    .nBOOTEN(b_nbooten), .DOUT0(d0), .DOUT1(d1), .byte_valid(b_bv),
    .byte_ready(b_rdy), .byte_data(b_bd), .done(b_done), .overflow(b_ovf),
    .checksum(b_cs)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Negedge monitor: edge timestamps, pulse widths and received bytes.
  int         ncyc = 0, t_bsen = 0, t_rep = 0, rep_low = 0, boot_bad = 0;
  int         a_done_cnt = 0, b_done_cnt = 0;
  logic       prev_bsen = 1'b1, prev_rep = 1'b1, boot_exp = 1'b0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always @(negedge clk) begin
    ncyc++;
    if (prev_bsen && !a_nbsen) t_bsen = ncyc;
    if (prev_rep && !a_nrepen) t_rep = ncyc;
    if (!a_nrepen) rep_low++;
    if (a_nbooten !== (boot_exp ? a_nbsen : 1'b1)) boot_bad++;
    if (a_bv && a_rdy) qa.push_back(a_bd);
    if (b_bv && b_rdy) qb.push_back(b_bd);
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    prev_bsen = a_nbsen;
    prev_rep  = a_nrepen;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_done(input int target);
    int n = 0;
    while (a_done_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    check("a_done_reached", 32'(a_done_cnt >= target), 32'd1);
  endtask

  task automatic clear_trackers();
    rep_low  = 0;
    boot_bad = 0;
    t_bsen   = 0;
    t_rep    = 0;
    qa.delete();
    qb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nbsen"},   32'(a_nbsen),     32'd1);
    check({tag, "_nrepen"},  32'(a_nrepen),    32'd1);
    check({tag, "_nbooten"}, 32'(a_nbooten),   32'd1);
    check({tag, "_ready"},   32'(a_cmd_ready), 32'd1);
    check({tag, "_bvalid"},  32'(a_bv),        32'd0);
    check({tag, "_bdata"},   32'(a_bd),        32'h00);
    check({tag, "_done"},    32'(a_done),      32'd0);
    check({tag, "_ovf"},     32'(a_ovf),       32'd0);
    check({tag, "_csum"},    32'(a_cs),        32'h00);
  endtask

  task automatic start_a();
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; boot = 1'b0; page = 12'd0;
    d0 = 1'b0; d1 = 1'b0; a_rdy = 1'b1; b_rdy = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Page 0, boot loop, DOUT0=1/DOUT1=0 -> six 0x55 bytes; stray command ignored.
    page = 12'd0; boot = 1'b1; boot_exp = 1'b1; d0 = 1'b1; d1 = 1'b0;
    repeat (4) tick();
    clear_trackers();
    start_a();
    check("p0_nbsen_low",   32'(a_nbsen),     32'd0);
    check("p0_nbooten_low", 32'(a_nbooten),   32'd0);
    check("p0_ready_low",   32'(a_cmd_ready), 32'd0);
    a_valid = 1'b1; page = 12'd7;
    repeat (5) tick();
    check("p0_ready_busy",  32'(a_cmd_ready), 32'd0);
    a_valid = 1'b0; page = 12'd0;
    wait_a_done(1);
    check("p0_rep_delay",   32'(t_rep - t_bsen), 32'd20);
    check("p0_rep_width",   32'(rep_low),        32'd3);
    check("p0_boot_track",  32'(boot_bad),       32'd0);
    check("p0_nbytes",      32'(qa.size()),      32'd6);
    for (int i = 0; i < qa.size(); i++) check("p0_byte", 32'(qa[i]), 32'h55);
    check("p0_csum",        32'(a_cs),           32'h00);
    repeat (20) tick();
    check("p0_no_restart",  32'(a_nbsen),        32'd1);
    check("p0_single_done", 32'(a_done_cnt),     32'd1);

    // Page 5, no boot: replicator falls T_SETUP + 5*T_BIT after nBSEN.
    page = 12'd5; boot = 1'b0; boot_exp = 1'b0; d0 = 1'b0; d1 = 1'b1;
    repeat (4) tick();
    clear_trackers();
    start_a();
    wait_a_done(2);
    check("p5_rep_delay",   32'(t_rep - t_bsen), 32'd60);
    check("p5_rep_width",   32'(rep_low),        32'd3);
    check("p5_boot_high",   32'(boot_bad),       32'd0);
    check("p5_nbytes",      32'(qa.size()),      32'd6);
    if (qa.size() == 6) begin
      check("p5_byte0", 32'(qa[0]), 32'hAA);
      check("p5_byte5", 32'(qa[5]), 32'hAA);
    end

    // Consumer stalled: 4 bytes buffered, last two dropped, overflow sticky.
    page = 12'd1; d0 = 1'b1; d1 = 1'b1; a_rdy = 1'b0;
    repeat (4) tick();
    clear_trackers();
    start_a();
    begin
      int n = 0;
      while (a_nbsen == 1'b0 && n < 2000) begin
        tick();
        n++;
      end
    end
    tick();
    check("ovf_flag",      32'(a_ovf),       32'd1);
    check("ovf_bvalid",    32'(a_bv),        32'd1);
    check("ovf_bdata",     32'(a_bd),        32'hFF);
    check("ovf_no_done",   32'(a_done_cnt),  32'd2);
    a_rdy = 1'b1;
    wait_a_done(3);
    check("ovf_nbytes",    32'(qa.size()),   32'd4);
    check("ovf_sticky",    32'(a_ovf),       32'd1);
    check("ovf_csum",      32'(a_cs),        32'h00);

    // Reset in the middle of DATA aborts at once; a new command then runs.
    page = 12'd0; d0 = 1'b1; d1 = 1'b0; a_rdy = 1'b0;
    repeat (2) tick();
    start_a();
    check("acc_ovf_clear", 32'(a_ovf), 32'd0);
    begin
      int n = 0;
      while (a_bv == 1'b0 && n < 2000) begin
        tick();
        n++;
      end
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    a_rdy = 1'b1;
    clear_trackers();
    start_a();
    check("post_rst_start", 32'(a_nbsen), 32'd0);
    wait_a_done(4);
    check("post_rst_nbytes", 32'(qa.size()), 32'd6);
    if (qa.size() > 0) check("post_rst_byte0", 32'(qa[0]), 32'h55);

    // Six positions: a full byte then a zero-padded half byte.
    d0 = 1'b1; d1 = 1'b1;
    repeat (4) tick();
    clear_trackers();
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    begin
      int n = 0;
      while (b_done_cnt < 1 && n < 2000) begin
        tick();
        n++;
      end
    end
    check("p6_done",   32'(b_done_cnt), 32'd1);
    check("p6_nbytes", 32'(qb.size()),  32'd2);
    if (qb.size() == 2) begin
      check("p6_byte0", 32'(qb[0]), 32'hFF);
      check("p6_byte1", 32'(qb[1]), 32'h0F);
    end
`ifdef BUBBLE_HOST_CHECKSUM_EN
    check("p6_csum", 32'(b_cs), 32'hF0);
`else
    check("p6_csum", 32'(b_cs), 32'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
